// File: rtl/wide_add_pkg.sv
`default_nettype none
// ============================================================================
// Module : wide_add_pkg
// Brief  : Shared types and default sizing for the wide-add sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package wide_add_pkg;

    localparam int c_default_width = 64;
    localparam int c_default_chunk = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter width that never collapses to zero bits for a single-chunk build.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// Module : chunk_adder
// Brief  : Combinational CHUNK-bit ripple-carry adder of full-add cells.
// Rev    : 1.0 - initial release
// ============================================================================
module chunk_adder #(
    parameter int CHUNK = 16
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ w_carry[i];
        assign w_carry[i+1] = (a[i] & b[i]) | (w_carry[i] & (a[i] ^ b[i]));
    end

    assign cout = w_carry[CHUNK];

endmodule
`default_nettype wire

// File: rtl/wide_add_sequencer.sv
`default_nettype none
// ============================================================================
// Module : wide_add_sequencer
// Brief  : WIDTH-bit adder time-multiplexed over one CHUNK-bit ripple adder.
// Rev    : 1.0 - initial release
// ============================================================================
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int WIDTH = c_default_width,
    parameter int CHUNK = c_default_chunk
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam int BASEW  = idx_width(WIDTH);

    localparam logic [1:0] c_st_idle = ST_IDLE;
    localparam logic [1:0] c_st_run  = ST_RUN;
    localparam logic [1:0] c_st_done = ST_DONE;

    logic [1:0]       r_state;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [BASEW-1:0] w_base;
    logic [CHUNK-1:0] w_chunk_a;
    logic [CHUNK-1:0] w_chunk_b;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;
    logic             w_last;

    assign w_base    = BASEW'(int'(r_idx) * CHUNK);
    assign w_chunk_a = r_a[w_base +: CHUNK];
    assign w_chunk_b = r_b[w_base +: CHUNK];
    assign w_last    = (r_idx == IDXW'(NCHUNK - 1));

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a    (w_chunk_a),
        .b    (w_chunk_b),
        .cin  (r_carry),
        .sum  (w_chunk_sum),
        .cout (w_chunk_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_idx       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (in_valid) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_carry    <= in_cin;
                        r_idx      <= '0;
                        r_state    <= c_st_run;
                        r_in_ready <= 1'b0;
                    end
                end
                c_st_run: begin
                    r_sum[w_base +: CHUNK] <= w_chunk_sum;
                    r_carry                <= w_chunk_cout;
                    if (w_last) begin
                        r_state     <= c_st_done;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                c_st_done: begin
                    // Result is held untouched until the consumer takes it.
                    if (out_ready) begin
                        r_state     <= c_st_idle;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= c_st_idle;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_sum;
    assign out_cout  = r_carry;

endmodule
`default_nettype wire

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-cycle controller that computes a WIDTH-bit addition by sequencing one CHUNK-bit ripple-carry adder over WIDTH/CHUNK cycles. A registered carry links the chunks, least-significant chunk first. It sits between an operand producer and a result consumer, each connected by a valid/ready handshake. It lets wide additions reuse a single narrow adder datapath instead of instantiating a full-width one.

## Interface
Parameters:
- WIDTH, 64, operand and result width; must be a positive multiple of CHUNK.
- CHUNK, 16, width of the shared adder datapath.
- Derived constant NCHUNK = WIDTH/CHUNK, not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set offered.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  addend A.
- in_b  in  WIDTH  addend B.
- in_cin  in  1  carry-in to chunk 0.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_sum  out  WIDTH  A+B+cin modulo 2^WIDTH.
- out_cout  out  1  carry out of bit WIDTH-1.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid: capture in_a, in_b into operand registers, carry_reg<=in_cin, idx<=0, then go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the adder computes a_reg[idx*CHUNK +: CHUNK] + b_reg[same] + carry_reg.
  - The chunk sum is written into sum_reg at the same slice; carry_reg<=chunk carry-out; idx<=idx+1.
  - On the cycle where idx==NCHUNK-1, go to DONE instead of incrementing.
- DONE:
  - out_valid=1, out_sum=sum_reg, out_cout=carry_reg.
  - On out_ready, go to IDLE.
  - While out_ready=0, hold out_sum/out_cout stable.
- in_valid is ignored outside IDLE. in_a/in_b/in_cin may change freely after acceptance.
- Arithmetic is unsigned; there is no overflow flag beyond out_cout.
- idx width is max(1, clog2(NCHUNK)).
- NCHUNK==1: RUN lasts exactly one cycle.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, idx=0, carry_reg=0, operand registers=0.
- Reset mid-RUN or mid-DONE discards the operation; the next cycle shows the reset values.
- Acceptance edge T (in_valid & in_ready sampled high). RUN occupies cycles T+1 … T+NCHUNK. out_valid rises in cycle T+NCHUNK+1.
- Result transfer happens on an edge with out_valid & out_ready. in_ready=1 in the following cycle.
- There is no same-cycle accept in DONE. Minimum initiation interval is NCHUNK+2 cycles.
- Outputs are driven from registers only. There is no combinational path from in_* or out_ready to any output.

## Structure
- Shared package `wide_add_pkg` holds:
  - the state enum type (IDLE, RUN, DONE);
  - the default WIDTH/CHUNK constants.
- One sub-module, `chunk_adder`: purely combinational CHUNK-bit ripple-carry adder (a, b, cin → sum, cout), built from bitwise full-add cells. Exactly one instance.
- The controller contains the FSM, idx counter, operand/sum/carry registers and handshake logic.

## Test plan
- Full carry chain: WIDTH=64, CHUNK=16; A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, cin=0, out_ready=1 → out_sum=0, out_cout=1, out_valid first high 5 cycles after the acceptance edge, then in_ready=1 the next cycle.
- Carry-in only: A=0, B=0, cin=1 → out_sum=0x1, out_cout=0. Then A=0x0000_FFFF_0000_FFFF, B=0x0000_0001_0000_0001, cin=0 → out_sum=0x0001_0000_0001_0000, out_cout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid stays 1, out_sum/out_cout unchanged, in_ready=0. in_valid pulses with different operands during this time do not alter the result. Release out_ready → a single transfer.
- Reset mid-RUN: assert rst at cycle T+2 of an operation → the next cycle shows in_ready=1, out_valid=0, out_sum=0. A fresh operation after reset produces a correct result.
- Degenerate config: WIDTH=CHUNK=16; A=0x8000, B=0x8000, cin=1 → out_sum=0x0001, out_cout=1, out_valid high 2 cycles after acceptance.
- Random regression: 1000 back-to-back random operations, out_ready randomly toggled → every result equals {cout,sum}=A+B+cin, and no result is lost or duplicated.
